// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared types, constants and helpers for the execute stage
package ex_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_JUMP = 4'd10
    } alu_op_e;

    localparam int PC_STEP = 4;

    // Widest datapath the sign-extension helper supports.
    localparam int SEXT_MAX_W = 64;

    // Sign-extend the low 'width' bits of v to SEXT_MAX_W; callers truncate to XLEN.
    function automatic logic [SEXT_MAX_W-1:0] sext(input logic [SEXT_MAX_W-1:0] v,
                                                   input int width);
        logic [SEXT_MAX_W-1:0] r;
        r = v;
        for (int i = 0; i < SEXT_MAX_W; i++) begin
            if (i >= width) r[i] = v[width-1];
        end
        return r;
    endfunction

endpackage

// File: rtl/ex_alu.sv
// rtl/ex_alu.sv - combinational ALU and jump link computation
module ex_alu
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_e         op,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] result,
    output logic            legal
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    assign shamt = b[SHW-1:0];

    // Select the operation result; undefined codes yield zero and flag illegal.
    always_comb begin
        result = '0;
        legal  = 1'b1;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $signed(a) >>> shamt;
            ALU_JUMP: result = pc + XLEN'(PC_STEP);
            default: begin
                result = '0;
                legal  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ex_stage_param.sv
// rtl/ex_stage_param.sv - execute stage owning register file, PC and result register
module ex_stage_param
    import ex_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter int              IMM_W    = 16,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [$clog2(NREGS)-1:0] rs1_addr,
    input  logic [$clog2(NREGS)-1:0] rs2_addr,
    input  logic [$clog2(NREGS)-1:0] rd_addr,
    input  logic [3:0]               alu_op,
    input  logic                     use_imm,
    input  logic                     reg_write,
    input  logic [IMM_W-1:0]         imm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          result,
    output logic [$clog2(NREGS)-1:0] wb_rd,
    output logic                     wb_en,
    output logic [XLEN-1:0]          pc,
    output logic                     jump_taken,
    output logic                     illegal_op
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] rf [NREGS];

    logic            accept;
    logic            commit;
    logic            is_jump;
    alu_op_e         op;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] alu_result;
    logic            alu_legal;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign op       = alu_op_e'(alu_op);
    assign is_jump  = (op == ALU_JUMP);
    assign imm_ext  = XLEN'(sext(SEXT_MAX_W'(imm), IMM_W));

    // r0 is hardwired to zero on the read side; reads see the current array state.
    assign op_a    = (rs1_addr == '0) ? '0 : rf[rs1_addr];
    assign rs2_val = (rs2_addr == '0) ? '0 : rf[rs2_addr];
    assign op_b    = use_imm ? imm_ext : rs2_val;

    // Writes to r0 and from undefined ops are dropped.
    assign commit = accept && reg_write && (rd_addr != AW'(0)) && alu_legal;

    ex_alu #(.XLEN(XLEN)) u_alu (
        .a      (op_a),
        .b      (op_b),
        .op     (op),
        .pc     (pc),
        .result (alu_result),
        .legal  (alu_legal)
    );

    // Register file: commit lands on the accept edge so the next op reads it directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (commit) begin
            rf[rd_addr] <= alu_result;
        end
    end

    // PC advances only on accept: relative jump or sequential step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= PC_RESET;
        end else if (accept) begin
            if (is_jump) pc <= pc + (imm_ext << 2);
            else         pc <= pc + XLEN'(PC_STEP);
        end
    end

    // Output register: load on accept, drop valid once consumed, hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            result     <= '0;
            wb_rd      <= '0;
            wb_en      <= 1'b0;
            jump_taken <= 1'b0;
            illegal_op <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            result     <= alu_legal ? alu_result : '0;
            wb_rd      <= rd_addr;
            wb_en      <= commit;
            jump_taken <= is_jump;
            illegal_op <= !alu_legal;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage_param.sv
// tb/tb_ex_stage_param.sv - directed self-checking bench for ex_stage_param
module tb_ex_stage_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [3:0]  alu_op;
    logic        use_imm;
    logic        reg_write;
    logic [15:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  wb_rd;
    logic        wb_en;
    logic [31:0] pc;
    logic        jump_taken;
    logic        illegal_op;

    int passed = 0;
    int total  = 0;

    localparam logic [3:0] ADD = 4'd1, SUB = 4'd2, AND_ = 4'd3, OR_ = 4'd4, XOR_ = 4'd5,
                           SLT = 4'd6, SLL = 4'd7, SRL = 4'd8, SRA = 4'd9, JMP = 4'd10;

    always #5 clk = ~clk;

    ex_stage_param dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rd_addr    (rd_addr),
        .alu_op     (alu_op),
        .use_imm    (use_imm),
        .reg_write  (reg_write),
        .imm        (imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .wb_rd      (wb_rd),
        .wb_en      (wb_en),
        .pc         (pc),
        .jump_taken (jump_taken),
        .illegal_op (illegal_op)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive(input logic [3:0] op, input int rd, input int rs1, input int rs2,
                         input logic ui, input logic [15:0] im, input logic we);
        alu_op    = op;
        rd_addr   = 5'(rd);
        rs1_addr  = 5'(rs1);
        rs2_addr  = 5'(rs2);
        use_imm   = ui;
        imm       = im;
        reg_write = we;
        in_valid  = 1'b1;
    endtask

    // Present one op with out_ready high, clock it in, sample #1 after the edge.
    task automatic issue(input logic [3:0] op, input int rd, input int rs1, input int rs2,
                         input logic ui, input logic [15:0] im, input logic we);
        drive(op, rd, rs1, rs2, ui, im, we);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        rs1_addr = '0; rs2_addr = '0; rd_addr = '0; alu_op = '0;
        use_imm = 1'b0; reg_write = 1'b0; imm = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_pc", pc, 32'h0);
        chk("reset_result", result, 32'h0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(ADD, 1, 0, 0, 1'b1, 16'h0001, 1'b1);
        chk("add1_out_valid", 32'(out_valid), 32'd1);
        chk("add1_result", result, 32'h1);
        chk("add1_pc", pc, 32'h4);

        issue(ADD, 3, 1, 0, 1'b1, 16'h0012, 1'b1);
        chk("add3_result", result, 32'h13);
        chk("add3_wb_en", 32'(wb_en), 32'd1);
        chk("add3_wb_rd", 32'(wb_rd), 32'd3);
        chk("add3_pc", pc, 32'h8);

        issue(SUB, 2, 1, 0, 1'b1, 16'h1212, 1'b1);
        chk("sub_result", result, 32'hFFFFEDEF);
        issue(SRA, 4, 2, 0, 1'b1, 16'h0004, 1'b1);
        chk("sra_result", result, 32'hFFFFFEDE);
        issue(ADD, 5, 3, 4, 1'b0, 16'h0000, 1'b1);
        chk("add_rr_result", result, 32'hFFFFFEF1);
        chk("add_rr_pc", pc, 32'h14);

        issue(JMP, 0, 0, 0, 1'b1, 16'h003B, 1'b0);
        chk("jmp1_result", result, 32'h18);
        chk("jmp1_pc", pc, 32'h100);
        issue(JMP, 0, 0, 0, 1'b1, 16'hFFFF, 1'b0);
        chk("jmp2_result", result, 32'h104);
        chk("jmp2_pc", pc, 32'hFC);
        chk("jmp2_taken", 32'(jump_taken), 32'd1);
        issue(JMP, 0, 0, 0, 1'b1, 16'hFFC0, 1'b0);
        chk("jmp3_pc", pc, 32'hFFFFFFFC);
        issue(JMP, 0, 0, 0, 1'b1, 16'h0001, 1'b0);
        chk("jmp_wrap_pc", pc, 32'h0);
        chk("jmp_wrap_result", result, 32'h0);

        issue(ADD, 6, 0, 0, 1'b1, 16'h0007, 1'b1);
        chk("add6_result", result, 32'h7);
        chk("add6_jump_clear", 32'(jump_taken), 32'd0);

        drive(ADD, 7, 6, 0, 1'b1, 16'h0001, 1'b1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_result", result, 32'h7);
            chk("bp_pc", pc, 32'h4);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("release_result", result, 32'h8);
        chk("release_wb_rd", 32'(wb_rd), 32'd7);
        chk("release_pc", pc, 32'h8);
        @(posedge clk); #1;
        chk("drain_out_valid", 32'(out_valid), 32'd0);
        chk("drain_pc", pc, 32'h8);

        issue(ADD, 0, 6, 0, 1'b1, 16'h0005, 1'b1);
        chk("r0_write_result", result, 32'hC);
        chk("r0_write_wb_en", 32'(wb_en), 32'd0);
        issue(ADD, 8, 0, 0, 1'b0, 16'h0000, 1'b1);
        chk("r0_read", result, 32'h0);

        issue(4'hF, 7, 6, 0, 1'b1, 16'h0003, 1'b1);
        chk("illegal_flag", 32'(illegal_op), 32'd1);
        chk("illegal_result", result, 32'h0);
        chk("illegal_wb_en", 32'(wb_en), 32'd0);
        chk("illegal_pc", pc, 32'h14);
        issue(ADD, 10, 7, 0, 1'b1, 16'h0000, 1'b1);
        chk("illegal_no_write", result, 32'h8);
        chk("illegal_clear", 32'(illegal_op), 32'd0);

        issue(SLT, 11, 2, 6, 1'b0, 16'h0000, 1'b1);
        chk("slt_result", result, 32'h1);
        issue(SLL, 12, 6, 0, 1'b1, 16'h0004, 1'b1);
        chk("sll_result", result, 32'h70);
        issue(SRL, 13, 2, 0, 1'b1, 16'h0004, 1'b1);
        chk("srl_result", result, 32'h0FFFFEDE);
        issue(XOR_, 14, 6, 0, 1'b1, 16'hFFFF, 1'b1);
        chk("xor_result", result, 32'hFFFFFFF8);
        issue(OR_, 15, 6, 0, 1'b1, 16'h0010, 1'b1);
        chk("or_result", result, 32'h17);
        issue(AND_, 16, 2, 6, 1'b0, 16'h0000, 1'b1);
        chk("and_result", result, 32'h7);
        chk("and_pc", pc, 32'h30);

        issue(ADD, 1, 1, 0, 1'b1, 16'h0064, 1'b1);
        chk("pre_rst_result", result, 32'h65);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_pc", pc, 32'h0);
        chk("async_result", result, 32'h0);
        drive(ADD, 2, 0, 0, 1'b1, 16'h0005, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rst_edge_out_valid", 32'(out_valid), 32'd0);
        chk("rst_edge_pc", pc, 32'h0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(ADD, 3, 1, 2, 1'b0, 16'h0000, 1'b1);
        chk("post_rst_rf_clear", result, 32'h0);
        chk("post_rst_pc", pc, 32'h4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
